sdiv64by32: RTL

Sequential 64-by-32 divider; the inverse of the 32x32 Booth/Wallace multiplier in the same datapath. It takes a 64-bit dividend, in the same format as the multiplier's product, and a 32-bit divisor. It returns a 32-bit quotient and a 32-bit remainder using a radix-2 restoring iteration on magnitudes, with sign fix-up at the end. It sits beside `mplier32x32` in the arithmetic unit and shares its operand buses; a start/done handshake decouples it from the issue logic.

---
 rtl/sdiv64by32.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sdiv64by32.sv
// sdiv64by32: sequential 64/32 restoring divider on magnitudes with sign fix-up; start/done handshake, start ignored (not queued) while busy.
// Latency 34 cycles; with SDIV_EARLY_OUT_EN defined, divide-by-zero and high-overflow finish in 2 cycles.
module sdiv64by32 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 dz,
    output logic                 ovf
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t            state_q, state_d;
    logic              sgn_q, sgn_d;
    logic [DW-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              zero_q, zero_d;
    logic              hiovf_q, hiovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rmd_q, rmd_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;

    logic              dvd_neg, dvs_neg;
    logic [DW-1:0]     dvd_mag;
    logic [WIDTH-1:0]  dvs_mag;
    logic [WIDTH+1:0]  shl_w;
    logic [WIDTH:0]    diff;
    logic              ge;
    logic [WIDTH-1:0]  q_fix, r_fix;
    logic              range_fail;

    assign dvd_neg = sgn_q & dvd_q[DW-1];
    assign dvs_neg = sgn_q & dvs_q[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dvd_q : dvd_q;
    assign dvs_mag = dvs_neg ? -dvs_q : dvs_q;

    // During ITER dvs_q holds |divisor|; rem stays below it so shl_w fits in WIDTH+1 bits.
    assign shl_w = {rem_q, q_q[WIDTH-1]};
    assign ge    = shl_w >= {2'b00, dvs_q};
    assign diff  = shl_w[WIDTH:0] - {1'b0, dvs_q};

    assign q_fix      = qneg_q ? -q_q : q_q;
    assign r_fix      = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    assign range_fail = sgn_q & (qneg_q ? (q_q > MIN_NEG) : q_q[WIDTH-1]);

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        hiovf_d = hiovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PREP;
                    busy_d  = 1'b1;
                    sgn_d   = sgn;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                end
            end
            PREP: begin
                rem_d   = {1'b0, dvd_mag[DW-1:WIDTH]};
                q_d     = dvd_mag[WIDTH-1:0];
                dvs_d   = dvs_mag;
                qneg_d  = dvd_neg ^ dvs_neg;
                rneg_d  = dvd_neg;
                zero_d  = (dvs_q == '0);
                hiovf_d = (dvd_mag[DW-1:WIDTH] >= dvs_mag);
                cnt_d   = '0;
                state_d = ITER;
`ifdef SDIV_EARLY_OUT_EN
                if ((dvs_q == '0) || (dvd_mag[DW-1:WIDTH] >= dvs_mag)) begin
                    state_d = FIX;
                end
`endif
            end
            ITER: begin
                rem_d = ge ? diff : shl_w[WIDTH:0];
                q_d   = {q_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                // Divide-by-zero takes priority over either overflow source.
                if (zero_q) begin
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                    quo_d = '1;
                    rmd_d = dvd_q[WIDTH-1:0];
                end else if (hiovf_q || range_fail) begin
                    dz_d  = 1'b0;
                    ovf_d = 1'b1;
                    quo_d = sgn_q ? MIN_NEG : '1;
                    rmd_d = '0;
                end else begin
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                    quo_d = q_fix;
                    rmd_d = r_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sgn_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            hiovf_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            hiovf_q <= hiovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;
endmodule
